// File: rtl/key_mode_ctrl.sv
// key_mode_ctrl: mode FSM, edit-field selector and key strobes with long-press auto-repeat
// for the multifunction clock; all outputs registered.
module key_mode_ctrl #(
  parameter int LONG_CNT = 100,
  parameter int REP_CNT  = 20
) (
  input  logic       clk100hz,
  input  logic       rst_n,
  input  logic       key_mode,
  input  logic       key_sel,
  input  logic       key_inc,
  output logic [1:0] mode,
  output logic [1:0] field,
  output logic       editing,
  output logic       inc_pulse,
  output logic       ss_pulse,
  output logic       clr_pulse
);
  localparam int W = $clog2(LONG_CNT + 1);
  localparam logic [W-1:0] LMAX = W'(LONG_CNT);
  localparam logic [W-1:0] LM1  = W'(LONG_CNT - 1);
  localparam logic [W-1:0] RLD  = W'(LONG_CNT - REP_CNT);
  logic kq_mode_q, kq_sel_q, kq_inc_q;
  logic [1:0] mode_q, mode_d, field_q, field_d;
  logic editing_q, editing_d, inc_q, inc_d, ss_q, ss_d, clr_q, clr_d;
  logic [W-1:0] hcnt_q, hcnt_d, rcnt_q, rcnt_d;
  logic rrun_q, rrun_d;
  logic m_press, m_rel, m_held, s_press, i_press, i_held;
  logic force_nrm, advance, mchg, set_mode, rep_hit;
  assign m_press   = key_mode & ~kq_mode_q;
  assign m_rel     = ~key_mode & kq_mode_q;
  assign m_held    = key_mode & kq_mode_q;
  assign s_press   = key_sel & ~kq_sel_q;
  assign i_press   = key_inc & ~kq_inc_q;
  assign i_held    = key_inc & kq_inc_q;
  assign set_mode  = mode_q[0] ^ mode_q[1];
  // a saturated hold count marks a press already consumed by the long-press force
  assign force_nrm = m_held && hcnt_q == LM1;
  assign advance   = m_rel && hcnt_q != LMAX;
  assign mchg      = force_nrm | advance;
  assign rep_hit   = rrun_q && i_held && rcnt_q == LM1;
  always_ff @(posedge clk100hz or negedge rst_n) begin
    if (!rst_n) begin
      kq_mode_q <= 1'b0;
      kq_sel_q  <= 1'b0;
      kq_inc_q  <= 1'b0;
      mode_q    <= 2'd0;
      field_q   <= 2'd0;
      editing_q <= 1'b0;
      inc_q     <= 1'b0;
      ss_q      <= 1'b0;
      clr_q     <= 1'b0;
      hcnt_q    <= '0;
      rcnt_q    <= '0;
      rrun_q    <= 1'b0;
    end else begin
      kq_mode_q <= key_mode;
      kq_sel_q  <= key_sel;
      kq_inc_q  <= key_inc;
      mode_q    <= mode_d;
      field_q   <= field_d;
      editing_q <= editing_d;
      inc_q     <= inc_d;
      ss_q      <= ss_d;
      clr_q     <= clr_d;
      hcnt_q    <= hcnt_d;
      rcnt_q    <= rcnt_d;
      rrun_q    <= rrun_d;
    end
  end
  // repeat phase reloads so the next hit lands REP_CNT cycles later
  always_comb begin
    mode_d  = force_nrm ? 2'd0 : advance ? mode_q + 2'd1 : mode_q;
    field_d = mchg ? 2'd0 : (s_press && set_mode) ? (field_q == 2'd2 ? 2'd0 : field_q + 2'd1) : field_q;
    hcnt_d  = m_press ? '0 : (m_held && hcnt_q != LMAX) ? hcnt_q + 1'b1 : hcnt_q;
    rrun_d  = !mchg && key_inc && (i_press ? set_mode : rrun_q);
    rcnt_d  = i_press ? '0 : rep_hit ? RLD : (rrun_q && rcnt_q != LMAX) ? rcnt_q + 1'b1 : rcnt_q;
  end
  always_comb begin
    editing_d = mode_d == 2'd1 || mode_d == 2'd2;
    inc_d     = !mchg && set_mode && (i_press || rep_hit);
    ss_d      = !mchg && mode_q == 2'd3 && s_press;
    clr_d     = !mchg && mode_q == 2'd3 && i_press;
  end
  assign mode      = mode_q;
  assign field     = field_q;
  assign editing   = editing_q;
  assign inc_pulse = inc_q;
  assign ss_pulse  = ss_q;
  assign clr_pulse = clr_q;
endmodule

// File: tb/tb_key_mode_ctrl.sv
// tb_key_mode_ctrl: scoreboard bench; an event-level model predicts each cycle's outputs
// into a queue that a monitor drains one entry per clock edge.
module tb_key_mode_ctrl;
  localparam int L = 10;
  localparam int R = 3;
  logic clk = 1'b0, rst_n = 1'b0, key_mode = 1'b0, key_sel = 1'b0, key_inc = 1'b0;
  logic [1:0] mode, field;
  logic editing, inc_pulse, ss_pulse, clr_pulse;
  logic [8:0] expq[$];
  int n_cmp = 0, n_err = 0;
  int t = 0, m_t0 = 0, i_t0 = 0, m_mode = 0, m_field = 0;
  bit pm = 0, ps = 0, pi = 0, i_arm = 0;
  key_mode_ctrl #(.LONG_CNT(L), .REP_CNT(R)) dut (
    .clk100hz(clk), .rst_n(rst_n), .key_mode(key_mode), .key_sel(key_sel), .key_inc(key_inc),
    .mode(mode), .field(field), .editing(editing), .inc_pulse(inc_pulse),
    .ss_pulse(ss_pulse), .clr_pulse(clr_pulse)
  );
  always #5 clk = ~clk;
  function automatic logic [8:0] outs();
    return {mode, field, editing, inc_pulse, ss_pulse, clr_pulse};
  endfunction
  initial begin
    logic [8:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() != 0) begin
        e = expq.pop_front();
        n_cmp++;
        if (outs() !== e) begin
          n_err++;
          $display("FAIL cycle t=%0t {mode,field,edit,inc,ss,clr} got %b expected %b", $time, outs(), e);
        end
      end
    end
  end
  task automatic step(input bit km, input bit ks, input bit ki);
    bit mp, mr, ip, edit, force_n, adv, inc, ss, clr;
    int d;
    @(negedge clk);
    rst_n = 1'b1;
    key_mode = km; key_sel = ks; key_inc = ki;
    t++;
    mp = km && !pm; mr = !km && pm; ip = ki && !pi;
    edit = m_mode == 1 || m_mode == 2;
    force_n = km && pm && (t - m_t0) == L;
    adv = mr && (t - m_t0) <= L;
    inc = 0; ss = 0; clr = 0;
    if (mp) m_t0 = t;
    if (force_n || adv) begin
      m_mode = force_n ? 0 : (m_mode + 1) % 4;
      m_field = 0;
      i_arm = 0;
    end else begin
      if (ks && !ps && edit) m_field = (m_field + 1) % 3;
      if (ks && !ps && m_mode == 3) ss = 1;
      if (ip) begin
        i_arm = edit; i_t0 = t;
        if (edit) inc = 1;
        if (m_mode == 3) clr = 1;
      end else if (ki && pi && i_arm) begin
        d = t - i_t0;
        if (d >= L && (d - L) % R == 0) inc = 1;
      end
    end
    if (!ki) i_arm = 0;
    pm = km; ps = ks; pi = ki;
    expq.push_back({2'(m_mode), 2'(m_field), 1'(m_mode == 1 || m_mode == 2), inc, ss, clr});
  endtask
  task automatic hold(input bit km, input bit ks, input bit ki, input int n);
    for (int k = 0; k < n; k++) step(km, ks, ki);
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_cmp++;
      if (outs() !== 9'd0) begin
        n_err++;
        $display("FAIL reset outputs got %b expected %b", outs(), 9'd0);
      end
      @(negedge clk);
      key_mode = 1'($urandom); key_sel = 1'($urandom); key_inc = 1'($urandom);
    end
    key_inc = 1'b0;
    pm = 0; ps = 0; pi = 0; i_arm = 0; m_mode = 0; m_field = 0;
  endtask
  initial begin
    bit km, ks, ki;
    do_reset();
    hold(0, 0, 0, 3);
    for (int k = 0; k < 4; k++) begin hold(1, 0, 0, 3); hold(0, 0, 0, 2); end
    hold(1, 0, 0, 3); hold(0, 0, 0, 2);
    for (int k = 0; k < 3; k++) begin hold(0, 1, 0, 2); hold(0, 0, 0, 2); end
    hold(1, 0, 0, 2); hold(0, 0, 0, 2);
    hold(1, 0, 0, 15); hold(0, 0, 0, 3);
    for (int k = 0; k < 2; k++) begin hold(1, 0, 0, 2); hold(0, 0, 0, 2); end
    hold(0, 0, 1, 20); hold(0, 0, 0, 3);
    hold(1, 0, 0, 2); hold(0, 0, 0, 2);
    hold(0, 1, 0, 2); hold(0, 0, 0, 2);
    hold(0, 0, 1, 20); hold(0, 0, 0, 2);
    hold(1, 0, 0, 3); step(0, 0, 1); hold(0, 0, 1, 4); hold(0, 0, 0, 2);
    hold(1, 1, 1, 4);
    do_reset();
    key_mode = 1'b1;
    hold(1, 0, 0, 4); hold(0, 0, 0, 3);
    km = 0; ks = 0; ki = 0;
    for (int k = 0; k < 2000; k++) begin
      if ($urandom_range(0, 15) == 0) km = !km;
      if ($urandom_range(0, 5) == 0) ks = !ks;
      if ($urandom_range(0, 11) == 0) ki = !ki;
      step(km, ks, ki);
      if ($urandom_range(0, 499) == 0) do_reset();
    end
    repeat (3) @(negedge clk);
    if (expq.size() != 0) begin
      n_err++;
      $display("FAIL drain pending got %0d expected %0d", expq.size(), 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
